// File: rtl/dot_product_arbiter.sv
// dot_product_arbiter
// Round-robin front end that shares one pipelined signed dot-product unit
// between NUM_REQ requesters. The winning operands are registered onto the
// datapath. A requester tag travels through a DP_LAT+1 stage pipe beside the
// operation, so the returning scalar can be steered back to its issuer.
// No arithmetic is done here: operands and results pass through bit-exact.
//
// Optional build feature (macro DP_ARB_STATS_EN):
//   When defined, the block adds one saturating 16-bit transfer counter per
//   requester. It also adds the stat_count_o output and the stat_clr_i input.
//   When undefined, neither the counters nor those ports exist.

module dot_product_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DP_LAT  = 2,
  parameter int VEC_W   = 57,
  parameter int SCL_W   = 19,
  parameter int ID_W    = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*VEC_W-1:0] req_vec_a_i,
  input  logic [NUM_REQ*VEC_W-1:0] req_vec_b_i,
  output logic [VEC_W-1:0]         dp_vec_1_o,
  output logic [VEC_W-1:0]         dp_vec_2_o,
  input  logic [SCL_W-1:0]         dp_scalar_i,
  output logic [NUM_REQ-1:0]       res_valid_o,
  output logic [ID_W-1:0]          res_id_o,
  output logic [SCL_W-1:0]         res_scalar_o,
  output logic                     idle_o
`ifdef DP_ARB_STATS_EN
  ,
  input  logic                     stat_clr_i,
  output logic [NUM_REQ*16-1:0]    stat_count_o
`endif
);

  // Round-robin pointer: the first requester index that gets priority.
  logic [ID_W-1:0]           rr_q;
  logic [ID_W-1:0]           rr_d;

  // Operand registers that drive the datapath.
  logic [VEC_W-1:0]          vec_1_q;
  logic [VEC_W-1:0]          vec_1_d;
  logic [VEC_W-1:0]          vec_2_q;
  logic [VEC_W-1:0]          vec_2_d;

  // Tag pipe. Stage DP_LAT lines up with dp_scalar_i.
  logic [DP_LAT:0]           tag_vld_q;
  logic [DP_LAT:0]           tag_vld_d;
  logic [DP_LAT:0][ID_W-1:0] tag_id_q;
  logic [DP_LAT:0][ID_W-1:0] tag_id_d;

  // Arbitration results.
  logic                      found_hi_s;
  logic                      found_lo_s;
  logic [ID_W-1:0]           win_hi_s;
  logic [ID_W-1:0]           win_lo_s;
  logic                      xfer_s;
  logic [ID_W-1:0]           win_s;
  logic [NUM_REQ-1:0]        grant_s;
  logic [VEC_W-1:0]          sel_a_s;
  logic [VEC_W-1:0]          sel_b_s;

  // Round-robin search. The first pass looks at indices at or above the
  // pointer. The second pass handles wrap-around from index 0. Only
  // req_valid_i and the pointer feed this logic, never req_ready_o itself.
  always_comb begin
    found_hi_s = 1'b0;
    found_lo_s = 1'b0;
    win_hi_s   = '0;
    win_lo_s   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found_hi_s && req_valid_i[j] && (ID_W'(j) >= rr_q)) begin
        found_hi_s = 1'b1;
        win_hi_s   = ID_W'(j);
      end else begin
        found_hi_s = found_hi_s;
      end
      if (!found_lo_s && req_valid_i[j]) begin
        found_lo_s = 1'b1;
        win_lo_s   = ID_W'(j);
      end else begin
        found_lo_s = found_lo_s;
      end
    end
  end

  // Pick the winner. When en_i is low no grant is issued at all.
  always_comb begin
    xfer_s = 1'b0;
    win_s  = '0;
    if (en_i && found_hi_s) begin
      xfer_s = 1'b1;
      win_s  = win_hi_s;
    end else if (en_i && found_lo_s) begin
      xfer_s = 1'b1;
      win_s  = win_lo_s;
    end else begin
      xfer_s = 1'b0;
      win_s  = '0;
    end
  end

  // One-hot grant, and the operand slices of the winning requester.
  always_comb begin
    grant_s = '0;
    sel_a_s = '0;
    sel_b_s = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (xfer_s && (win_s == ID_W'(j))) begin
        grant_s[j] = 1'b1;
        sel_a_s    = req_vec_a_i[j*VEC_W +: VEC_W];
        sel_b_s    = req_vec_b_i[j*VEC_W +: VEC_W];
      end else begin
        grant_s[j] = 1'b0;
      end
    end
  end

  assign req_ready_o = grant_s;

  // Next state for the pointer, the operand registers and the tag pipe.
  // Operands hold when nothing transfers. The tag pipe always shifts.
  always_comb begin
    rr_d        = rr_q;
    vec_1_d     = vec_1_q;
    vec_2_d     = vec_2_q;
    tag_vld_d   = {tag_vld_q[DP_LAT-1:0], xfer_s};
    tag_id_d    = '0;
    tag_id_d[0] = xfer_s ? win_s : '0;
    for (int s = 1; s <= DP_LAT; s++) begin
      tag_id_d[s] = tag_id_q[s-1];
    end
    if (xfer_s) begin
      vec_1_d = sel_a_s;
      vec_2_d = sel_b_s;
      if (win_s == ID_W'(NUM_REQ - 1)) begin
        rr_d = '0;
      end else begin
        rr_d = win_s + ID_W'(1);
      end
    end else begin
      rr_d    = rr_q;
      vec_1_d = vec_1_q;
      vec_2_d = vec_2_q;
    end
  end

  // State registers. Reset discards every in-flight tag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      vec_1_q   <= '0;
      vec_2_q   <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      rr_q      <= rr_d;
      vec_1_q   <= vec_1_d;
      vec_2_q   <= vec_2_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  assign dp_vec_1_o = vec_1_q;
  assign dp_vec_2_o = vec_2_q;

  // Decode the final tag stage into the one-hot result strobe.
  always_comb begin
    res_valid_o = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (tag_vld_q[DP_LAT] && (tag_id_q[DP_LAT] == ID_W'(j))) begin
        res_valid_o[j] = 1'b1;
      end else begin
        res_valid_o[j] = 1'b0;
      end
    end
  end

  assign res_id_o     = tag_id_q[DP_LAT];
  assign res_scalar_o = dp_scalar_i;
  assign idle_o       = ~(|tag_vld_q);

`ifdef DP_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt_q;
  logic [NUM_REQ-1:0][15:0] cnt_d;

  // Per-requester transfer counters. They saturate at all-ones, and a clear
  // beats a simultaneous increment.
  always_comb begin
    cnt_d = cnt_q;
    if (stat_clr_i) begin
      cnt_d = '0;
    end else begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (grant_s[j] && (cnt_q[j] != 16'hFFFF)) begin
          cnt_d[j] = cnt_q[j] + 16'd1;
        end else begin
          cnt_d[j] = cnt_q[j];
        end
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stat_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_dot_product_arbiter.sv
// Self-checking bench for dot_product_arbiter. A two-stage behavioural
// datapath model computes the signed dot product. An arbitration model
// predicts the grants and pushes the expected results to a scoreboard queue.
module tb_dot_product_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DP_LAT  = 2;
  localparam int VEC_W   = 57;
  localparam int SCL_W   = 19;
  localparam int ID_W    = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     en;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*VEC_W-1:0] req_vec_a;
  logic [NUM_REQ*VEC_W-1:0] req_vec_b;
  logic [VEC_W-1:0]         dp_vec_1;
  logic [VEC_W-1:0]         dp_vec_2;
  logic [SCL_W-1:0]         dp_scalar;
  logic [NUM_REQ-1:0]       res_valid;
  logic [ID_W-1:0]          res_id;
  logic [SCL_W-1:0]         res_scalar;
  logic                     idle;
`ifdef DP_ARB_STATS_EN
  logic                     stat_clr;
  logic [NUM_REQ*16-1:0]    stat_count;
`endif

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [SCL_W-1:0] val;
  } exp_t;

  exp_t             exp_q[$];
  int               checks = 0;
  int               passed = 0;
  int               m_rr   = 0;
  logic [SCL_W-1:0] p1     = '0;
  logic [SCL_W-1:0] p2     = '0;

  always #5 clk = ~clk;

  dot_product_arbiter #(
    .NUM_REQ(NUM_REQ), .DP_LAT(DP_LAT), .VEC_W(VEC_W), .SCL_W(SCL_W), .ID_W(ID_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_vec_a_i(req_vec_a), .req_vec_b_i(req_vec_b),
    .dp_vec_1_o(dp_vec_1), .dp_vec_2_o(dp_vec_2),
    .dp_scalar_i(dp_scalar),
    .res_valid_o(res_valid), .res_id_o(res_id), .res_scalar_o(res_scalar),
    .idle_o(idle)
`ifdef DP_ARB_STATS_EN
    , .stat_clr_i(stat_clr), .stat_count_o(stat_count)
`endif
  );

  function automatic logic [VEC_W-1:0] pack3(input int x, input int y, input int z);
    return {x[18:0], y[18:0], z[18:0]};
  endfunction

  function automatic logic [SCL_W-1:0] dot3(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    int ax, ay, az, bx, by, bz, acc;
    ax = $signed(a[56:38]); ay = $signed(a[37:19]); az = $signed(a[18:0]);
    bx = $signed(b[56:38]); by = $signed(b[37:19]); bz = $signed(b[18:0]);
    acc = ax * bx + ay * by + az * bz;
    return acc[18:0];
  endfunction

  // Behavioural datapath with a latency of DP_LAT = 2.
  always @(posedge clk) begin
    p1 <= dot3(dp_vec_1, dp_vec_2);
    p2 <= p1;
  end
  assign dp_scalar = p2;

  // Arbitration model and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_rdy;
    int win;
    exp_t e;
    if (rst) begin
      m_rr = 0;
      exp_q.delete();
    end else begin
      exp_rdy = '0;
      win = -1;
      if (en) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (win < 0 && req_valid[(m_rr + k) % NUM_REQ]) win = (m_rr + k) % NUM_REQ;
        end
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
      checks++;
      if (req_ready !== exp_rdy) $display("FAIL grant: got %b expected %b at %0t", req_ready, exp_rdy, $time);
      else passed++;
      if (|res_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_result: got res_valid=%b id=%0d expected no result at %0t", res_valid, res_id, $time);
        end else begin
          e = exp_q.pop_front();
          if (res_id !== e.id || res_valid !== (4'b0001 << e.id) || res_scalar !== e.val)
            $display("FAIL result: got id=%0d v=%b s=%h expected id=%0d s=%h at %0t",
                     res_id, res_valid, res_scalar, e.id, e.val, $time);
          else passed++;
        end
      end
      if (win >= 0) begin
        e.id  = ID_W'(win);
        e.val = dot3(req_vec_a[win*VEC_W +: VEC_W], req_vec_b[win*VEC_W +: VEC_W]);
        exp_q.push_back(e);
        m_rr = (win + 1) % NUM_REQ;
      end
    end
  end

  task automatic set_ops(input int r, input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    req_vec_a[r*VEC_W +: VEC_W] = a;
    req_vec_b[r*VEC_W +: VEC_W] = b;
  endtask

  task automatic fill_all();
    for (int r = 0; r < NUM_REQ; r++) set_ops(r, pack3(r + 1, -(r + 2), 3 * r), pack3(7, r, -5));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (dp_vec_1 !== '0) $display("FAIL reset_vec1: got %h expected 0", dp_vec_1); else passed++;
    checks++; if (dp_vec_2 !== '0) $display("FAIL reset_vec2: got %h expected 0", dp_vec_2); else passed++;
    checks++; if (res_valid !== '0) $display("FAIL reset_res_valid: got %b expected 0", res_valid); else passed++;
    checks++; if (res_id !== '0) $display("FAIL reset_res_id: got %0d expected 0", res_id); else passed++;
    checks++; if (idle !== 1'b1) $display("FAIL reset_idle: got %b expected 1", idle); else passed++;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single_issue();
    set_ops(1, pack3(1, 2, 3), pack3(4, 5, 6));
    en = 1'b1; req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (req_ready !== 4'b0010) $display("FAIL single_ready: got %b expected 0010", req_ready); else passed++;
      end
      if (k == 1) begin
        checks++; if (dp_vec_1 !== pack3(1, 2, 3)) $display("FAIL single_vec1: got %h expected %h", dp_vec_1, pack3(1, 2, 3)); else passed++;
        checks++; if (dp_vec_2 !== pack3(4, 5, 6)) $display("FAIL single_vec2: got %h expected %h", dp_vec_2, pack3(4, 5, 6)); else passed++;
      end
      if (k == 1 || k == 2) begin
        checks++; if (res_valid !== 4'b0000) $display("FAIL single_early: got %b expected 0000 (k=%0d)", res_valid, k); else passed++;
      end
      if (k == 3) begin
        checks++; if (res_valid !== 4'b0010) $display("FAIL single_res_valid: got %b expected 0010", res_valid); else passed++;
        checks++; if (res_id !== 3'd1) $display("FAIL single_res_id: got %0d expected 1", res_id); else passed++;
        checks++; if (res_scalar !== 19'd32) $display("FAIL single_scalar: got %0d expected 32", res_scalar); else passed++;
      end
      if (k == 4) begin
        checks++; if (idle !== 1'b1) $display("FAIL single_idle: got %b expected 1", idle); else passed++;
      end
      @(posedge clk); #1;
      if (k == 0) req_valid = '0;
    end
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] exp_g;
    do_reset();
    fill_all();
    req_valid = 4'hF;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k < 8) begin
        exp_g = 4'b0001 << (k % 4);
        checks++; if (req_ready !== exp_g) $display("FAIL rr_grant: got %b expected %b (k=%0d)", req_ready, exp_g, k); else passed++;
      end
      if (k >= 3) begin
        exp_g = 4'b0001 << ((k - 3) % 4);
        checks++; if (res_valid !== exp_g) $display("FAIL rr_res_valid: got %b expected %b (k=%0d)", res_valid, exp_g, k); else passed++;
        checks++; if (res_id !== ID_W'((k - 3) % 4)) $display("FAIL rr_res_id: got %0d expected %0d", res_id, (k - 3) % 4); else passed++;
      end
      @(posedge clk); #1;
      if (k == 7) req_valid = '0;
    end
  endtask

  task automatic test_signed();
    set_ops(2, pack3(-1, -2, 3), pack3(5, -4, -2));
    req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (req_ready !== 4'b0100) $display("FAIL signed_ready: got %b expected 0100", req_ready); else passed++;
      end
      if (k == 3) begin
        checks++; if (res_scalar !== 19'h7FFFD) $display("FAIL signed_scalar: got %h expected 7fffd", res_scalar); else passed++;
        checks++; if (res_id !== 3'd2) $display("FAIL signed_id: got %0d expected 2", res_id); else passed++;
      end
      @(posedge clk); #1;
      if (k == 0) req_valid = '0;
    end
  endtask

  task automatic test_enable_drain();
    fill_all();
    req_valid = 4'hF; en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 3) begin
        checks++; if (req_ready === 4'b0000) $display("FAIL drain_issue: got %b expected a grant", req_ready); else passed++;
      end else begin
        checks++; if (req_ready !== 4'b0000) $display("FAIL drain_ready: got %b expected 0000", req_ready); else passed++;
      end
      if (k >= 3 && k <= 5) begin
        checks++; if (res_valid === 4'b0000) $display("FAIL drain_result: got %b expected a result (k=%0d)", res_valid, k); else passed++;
      end
      if (k == 5) begin
        checks++; if (idle !== 1'b0) $display("FAIL drain_busy: got %b expected 0", idle); else passed++;
      end
      if (k == 6) begin
        checks++; if (idle !== 1'b1) $display("FAIL drain_idle: got %b expected 1", idle); else passed++;
      end
      @(posedge clk); #1;
      if (k == 2) en = 1'b0;
    end
    req_valid = '0; en = 1'b1;
  endtask

  task automatic test_reset_mid();
    fill_all();
    req_valid = 4'hF; en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 6) begin
        checks++; if (res_valid !== 4'b0000) $display("FAIL rstmid_res_valid: got %b expected 0000 (k=%0d)", res_valid, k); else passed++;
      end
      if (k == 2 || k == 3) begin
        checks++; if (idle !== 1'b1) $display("FAIL rstmid_idle: got %b expected 1", idle); else passed++;
      end
      if (k == 4) begin
        checks++; if (req_ready !== 4'b0001) $display("FAIL rstmid_grant: got %b expected 0001", req_ready); else passed++;
      end
      @(posedge clk); #1;
      if (k == 0) req_valid = '0;
      if (k == 1) rst = 1'b1;
      if (k == 3) begin rst = 1'b0; req_valid = 4'hF; end
      if (k == 4) req_valid = '0;
    end
  endtask

`ifdef DP_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    set_ops(0, pack3(2, -3, 4), pack3(-1, 6, 9));
    stat_clr = 1'b0; req_valid = 4'b0001;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 3) begin
        checks++; if (stat_count[15:0] !== 16'd3) $display("FAIL stats_count: got %0d expected 3", stat_count[15:0]); else passed++;
        checks++; if (stat_count[63:16] !== '0) $display("FAIL stats_others: got %h expected 0", stat_count[63:16]); else passed++;
      end
      if (k == 4 || k == 5) begin
        checks++; if (stat_count[15:0] !== 16'd0) $display("FAIL stats_clear: got %0d expected 0", stat_count[15:0]); else passed++;
      end
      @(posedge clk); #1;
      if (k == 2) stat_clr = 1'b1;
      if (k == 3) begin stat_clr = 1'b0; req_valid = '0; end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; req_valid = '0; req_vec_a = '0; req_vec_b = '0;
`ifdef DP_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_single_issue();
    test_round_robin();
    test_signed();
    test_enable_drain();
    test_reset_mid();
`ifdef DP_ARB_STATS_EN
    test_stats();
`endif
    repeat (6) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
